// File: rtl/lzx_cmp_pkg.sv
// Shared types and constants for the serial nibble-compare controller.
package lzx_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Cascade encoding, ordered {g,e,l}
  localparam logic [2:0] CASC_GT = 3'b100;
  localparam logic [2:0] CASC_EQ = 3'b010;
  localparam logic [2:0] CASC_LT = 3'b001;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } casc_t;

  // Stage counter width; a single-nibble word still needs one bit
  function automatic int unsigned cnt_width(input int unsigned nib);
    return (nib > 1) ? int'($clog2(nib)) : 1;
  endfunction

endpackage

// File: rtl/lzx_serial_cmp_ctrl_if.sv
// Requester-side start/done handshake and operand/result bundle.
interface lzx_serial_cmp_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_g;
  logic             in_e;
  logic             in_l;
  logic             busy;
  logic             done;
  logic             res_gt;
  logic             res_eq;
  logic             res_lt;

  modport master (
    output start, a, b, in_g, in_e, in_l,
    input  busy, done, res_gt, res_eq, res_lt
  );

  modport slave (
    input  start, a, b, in_g, in_e, in_l,
    output busy, done, res_gt, res_eq, res_lt
  );
endinterface

// File: rtl/lzx_74HC85.sv
// 4-bit magnitude comparator with cascade inputs (74HC85 truth table).
module lzx_74HC85 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ia_g,
  input  logic       ia_e,
  input  logic       ia_l,
  output logic       qa_g_c,
  output logic       qa_e_c,
  output logic       qa_l_c
);

  // Unequal nibble overrides the cascade; equal nibble follows the 74HC85 cascade rows
  always_comb begin
    qa_g_c = 1'b0;
    qa_e_c = 1'b0;
    qa_l_c = 1'b0;
    if (a > b) begin
      qa_g_c = 1'b1;
    end else if (a < b) begin
      qa_l_c = 1'b1;
    end else begin
      qa_g_c = ~ia_e & ~ia_l;
      qa_e_c = ia_e;
      qa_l_c = ~ia_e & ~ia_g;
    end
  end

endmodule

// File: rtl/lzx_serial_cmp_ctrl.sv
// Sequences one 4-bit comparator over a WIDTH-bit word pair, LSB nibble first,
// chaining each stage's result into the next stage's cascade inputs.
module lzx_serial_cmp_ctrl
  import lzx_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lzx_serial_cmp_ctrl_if.slave bus
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned CNT_W = cnt_width(NIB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  casc_t            casc_q, casc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  casc_t            res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             cmp_g, cmp_e, cmp_l;
  casc_t            cmp_out;

  // Nibble mux into the shared comparator
  assign nib_a   = a_q[{cnt_q, 2'b00} +: 4];
  assign nib_b   = b_q[{cnt_q, 2'b00} +: 4];
  assign cmp_out = {cmp_g, cmp_e, cmp_l};

  lzx_74HC85 u_cmp (
    .a      (nib_a),
    .b      (nib_b),
    .ia_g   (casc_q.g),
    .ia_e   (casc_q.e),
    .ia_l   (casc_q.l),
    .qa_g_c (cmp_g),
    .qa_e_c (cmp_e),
    .qa_l_c (cmp_l)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; busy/done/res are computed one edge ahead so the outputs are registered
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    casc_d  = casc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          casc_d  = {bus.in_g, bus.in_e, bus.in_l};
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        casc_d = cmp_out;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          res_d   = cmp_out;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.res_gt = res_q.g;
  assign bus.res_eq = res_q.e;
  assign bus.res_lt = res_q.l;

endmodule
